// File: rtl/exc_pkg.sv
// Shared types and constants for the exception responder and the ID decoder.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } exc_state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int CW_JUMP   = 10;
  localparam int CW_BRANCH = 9;
  localparam int CW_EXC    = 3;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational exception source arbitration: EX overflow beats ID reserved-instruction.
// Overflow source exists only when EXC_OVERFLOW_EN is defined.
module exc_prio
  import exc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [10:0]     ctrl_word,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
`ifdef EXC_OVERFLOW_EN
  input  logic            ex_ovf,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
`endif
  output logic            exc_req,
  output logic [4:0]      exc_cause,
  output logic [PC_W-1:0] exc_pc
);

  logic w_ri;
  logic w_ov;
  logic w_unused_cw;

  // Only the exception bit matters here; the rest of the word belongs to the decoder.
  assign w_unused_cw = ^{ctrl_word[10:CW_EXC+1], ctrl_word[CW_EXC-1:0]};
  assign w_ri = id_valid & ctrl_word[CW_EXC];

`ifdef EXC_OVERFLOW_EN
  assign w_ov = ex_valid & ex_ovf;
`else
  assign w_ov = 1'b0;
`endif

  always_comb begin
    exc_req   = w_ov | w_ri;
    exc_cause = EXC_NONE;
    exc_pc    = id_pc;
`ifdef EXC_OVERFLOW_EN
    if (w_ov) begin
      exc_cause = EXC_OV;
      exc_pc    = ex_pc;
    end else if (w_ri) begin
      exc_cause = EXC_RI;
    end
`else
    if (w_ri) exc_cause = EXC_RI;
`endif
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception responder: records EPC/cause, flushes and redirects to the handler, returns on eret.
// EXC_OVERFLOW_EN adds the EX-stage overflow source and its ports.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] HANDLER_VEC = PC_W'(32'h8000_0180)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [10:0]     ctrl_word,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
`ifdef EXC_OVERFLOW_EN
  input  logic            ex_ovf,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
`endif
  input  logic            eret_valid,
  output logic            flush_if,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            redirect_valid,
  output logic [PC_W-1:0] pc_redirect,
  output logic [PC_W-1:0] epc,
  output logic [4:0]      cause,
  output logic            in_handler,
  output logic            halted
);

  exc_state_t      r_state;
  exc_state_t      w_state_nxt;
  logic [PC_W-1:0] r_epc;
  logic [PC_W-1:0] w_epc_nxt;
  logic [4:0]      r_cause;
  logic [4:0]      w_cause_nxt;
  logic [PC_W-1:0] r_pc_redirect;
  logic [PC_W-1:0] w_pc_redirect_nxt;
  logic            w_exc_req;
  logic [4:0]      w_exc_cause;
  logic [PC_W-1:0] w_exc_pc;

  exc_prio #(.PC_W(PC_W)) u_prio (
    .ctrl_word (ctrl_word),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
`ifdef EXC_OVERFLOW_EN
    .ex_ovf    (ex_ovf),
    .ex_valid  (ex_valid),
    .ex_pc     (ex_pc),
`endif
    .exc_req   (w_exc_req),
    .exc_cause (w_exc_cause),
    .exc_pc    (w_exc_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_epc         <= '0;
      r_cause       <= EXC_NONE;
      r_pc_redirect <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_epc         <= w_epc_nxt;
      r_cause       <= w_cause_nxt;
      r_pc_redirect <= w_pc_redirect_nxt;
    end
  end

  // The redirect target is loaded on the edge entering FLUSH/RETURN so it is valid for that whole cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_epc_nxt         = r_epc;
    w_cause_nxt       = r_cause;
    w_pc_redirect_nxt = r_pc_redirect;
    case (r_state)
      ST_IDLE: begin
        if (w_exc_req) begin
          w_state_nxt       = ST_FLUSH;
          w_epc_nxt         = w_exc_pc;
          w_cause_nxt       = w_exc_cause;
          w_pc_redirect_nxt = HANDLER_VEC;
        end
      end
      ST_FLUSH:   w_state_nxt = ST_HANDLER;
      ST_HANDLER: begin
        if (w_exc_req) begin
          w_state_nxt = ST_HALT;
        end else if (id_valid && eret_valid) begin
          w_state_nxt       = ST_RETURN;
          w_pc_redirect_nxt = r_epc;
        end
      end
      ST_RETURN:  w_state_nxt = ST_IDLE;
      ST_HALT:    w_state_nxt = ST_HALT;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign flush_if       = (r_state == ST_FLUSH) || (r_state == ST_RETURN) || (r_state == ST_HALT);
  assign flush_id       = flush_if;
`ifdef EXC_OVERFLOW_EN
  assign flush_ex       = (r_state == ST_FLUSH) || (r_state == ST_HALT);
`else
  assign flush_ex       = (r_state == ST_HALT);
`endif
  assign redirect_valid = (r_state == ST_FLUSH) || (r_state == ST_RETURN);
  assign in_handler     = (r_state == ST_HANDLER) || (r_state == ST_RETURN);
  assign halted         = (r_state == ST_HALT);
  assign pc_redirect    = r_pc_redirect;
  assign epc            = r_epc;
  assign cause          = r_cause;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] ctrl_word;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        ex_ovf;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        eret_valid;
  logic        flush_if, flush_id, flush_ex, redirect_valid, in_handler, halted;
  logic [31:0] pc_redirect, epc;
  logic [4:0]  cause;

  int checks = 0;
  int errors = 0;

  // model: pending one-cycle pulses plus handler/halt flags
  bit          m_entry, m_ret, m_in_h, m_halt;
  logic [31:0] m_epc, m_pcr;
  logic [4:0]  m_cause;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_word      (ctrl_word),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
`ifdef EXC_OVERFLOW_EN
    .ex_ovf         (ex_ovf),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
`endif
    .eret_valid     (eret_valid),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .redirect_valid (redirect_valid),
    .pc_redirect    (pc_redirect),
    .epc            (epc),
    .cause          (cause),
    .in_handler     (in_handler),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ri, ov;
    ri = id_valid && ctrl_word[3];
`ifdef EXC_OVERFLOW_EN
    ov = ex_valid && ex_ovf;
`else
    ov = 1'b0;
`endif
    if (!rst_n) begin
      {m_entry, m_ret, m_in_h, m_halt} = '0;
      m_epc = '0; m_pcr = '0; m_cause = '0;
    end else if (m_halt) begin
    end else if (m_entry) begin
      m_entry = 0; m_in_h = 1;
    end else if (m_ret) begin
      m_ret = 0; m_in_h = 0;
    end else if (m_in_h) begin
      if (ri || ov) begin
        m_halt = 1; m_in_h = 0;
      end else if (id_valid && eret_valid) begin
        m_ret = 1; m_pcr = m_epc;
      end
    end else if (ov) begin
      m_entry = 1; m_epc = ex_pc; m_cause = 5'd12; m_pcr = VEC;
    end else if (ri) begin
      m_entry = 1; m_epc = id_pc; m_cause = 5'd10; m_pcr = VEC;
    end
  endtask

  task automatic compare_all();
    bit fl, fx;
    fl = m_entry || m_ret || m_halt;
`ifdef EXC_OVERFLOW_EN
    fx = m_halt || m_entry;
`else
    fx = m_halt;
`endif
    chk("flush_if", 32'(flush_if), 32'(fl));
    chk("flush_id", 32'(flush_id), 32'(fl));
    chk("flush_ex", 32'(flush_ex), 32'(fx));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_entry || m_ret));
    chk("pc_redirect", pc_redirect, m_pcr);
    chk("epc", epc, m_epc);
    chk("cause", 32'(cause), 32'(m_cause));
    chk("in_handler", 32'(in_handler), 32'(m_in_h || m_ret));
    chk("halted", 32'(halted), 32'(m_halt));
  endtask

  // Inputs are set at the negedge; one tick advances to the next negedge and checks.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_in();
    logic [10:0] cw;
    cw = 11'($urandom);
    cw[3] = 1'b0;
    rst_n = 1; ctrl_word = cw; id_valid = 0; id_pc = 32'($urandom);
    ex_ovf = 0; ex_valid = 0; ex_pc = 32'($urandom); eret_valid = 0;
  endtask

  initial begin
    @(negedge clk);
    idle_in(); rst_n = 0;
    tick(); tick();
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_epc", epc, 32'd0);

    // exception entry
    idle_in(); ctrl_word = 11'b00000001000; id_valid = 1; id_pc = 32'h40;
    tick();
    chk("tp_entry_redir", 32'(redirect_valid), 32'd1);
    chk("tp_entry_pc", pc_redirect, VEC);
    chk("tp_entry_epc", epc, 32'h40);
    chk("tp_entry_cause", 32'(cause), 32'd10);
    chk("tp_entry_flush_if", 32'(flush_if), 32'd1);
    idle_in(); tick();
    chk("tp_handler", 32'(in_handler), 32'd1);
    chk("tp_handler_redir", 32'(redirect_valid), 32'd0);

    // return
    idle_in(); id_valid = 1; eret_valid = 1; tick();
    chk("tp_ret_redir", 32'(redirect_valid), 32'd1);
    chk("tp_ret_pc", pc_redirect, 32'h40);
    chk("tp_ret_inh", 32'(in_handler), 32'd1);
    idle_in(); tick();
    chk("tp_ret_done", 32'(in_handler), 32'd0);

    // stray eret and bubble in IDLE
    idle_in(); id_valid = 1; eret_valid = 1; tick();
    chk("tp_stray_eret", 32'(redirect_valid), 32'd0);
    idle_in(); ctrl_word[3] = 1; id_valid = 0; tick();
    chk("tp_bubble", 32'(redirect_valid), 32'd0);
    chk("tp_bubble_epc", epc, 32'h40);

    // double fault
    idle_in(); ctrl_word[3] = 1; id_valid = 1; id_pc = 32'h80; tick();
    idle_in(); tick();
    idle_in(); ctrl_word[3] = 1; id_valid = 1; id_pc = 32'h99; tick();
    chk("tp_halt", 32'(halted), 32'd1);
    chk("tp_halt_epc", epc, 32'h80);
    idle_in(); id_valid = 1; eret_valid = 1; tick(); tick();
    chk("tp_halt_stays", 32'(halted), 32'd1);
    idle_in(); rst_n = 0; tick();
    chk("tp_halt_rst", 32'(halted), 32'd0);
    chk("tp_halt_rst_epc", epc, 32'd0);

    // reset on the edge ending FLUSH
    idle_in(); ctrl_word[3] = 1; id_valid = 1; id_pc = 32'h44; tick();
    idle_in(); rst_n = 0; tick();
    chk("tp_rstflush_redir", 32'(redirect_valid), 32'd0);
    chk("tp_rstflush_inh", 32'(in_handler), 32'd0);
    chk("tp_rstflush_epc", epc, 32'd0);

`ifdef EXC_OVERFLOW_EN
    idle_in(); tick();
    idle_in(); ctrl_word[3] = 1; id_valid = 1; id_pc = 32'h40;
    ex_valid = 1; ex_ovf = 1; ex_pc = 32'h3C; tick();
    chk("tp_prio_epc", epc, 32'h3C);
    chk("tp_prio_cause", 32'(cause), 32'd12);
`endif

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      idle_in();
      rst_n      = ($urandom_range(0, 59) != 0);
      id_valid   = $urandom_range(0, 1) == 1;
      ctrl_word[3] = ($urandom_range(0, 7) == 0);
      eret_valid = ($urandom_range(0, 4) == 0);
      ex_valid   = $urandom_range(0, 1) == 1;
      ex_ovf     = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
